// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and constants for the memory request queue.
//   req_t        - queued request {wr, addr, data}
//   state_t      - issue FSM states (IDLE / BUSY)
//   HIT_MAX_LAT  - longest acceptable hit latency, in cycles from issue
//   MISS_MAX_LAT - longest acceptable miss latency, in cycles from issue
package mem_req_pkg;

  localparam int unsigned LAT_W = 8;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [LAT_W-1:0] HIT_MAX_LAT  = 8'd2;
  localparam logic [LAT_W-1:0] MISS_MAX_LAT = 8'd20;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: DEPTH-entry request FIFO (DEPTH a power of two, >= 2).
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push, i_push_req   write one request (ignored when full)
//   i_pop                drop the head entry (ignored when empty)
//   o_head               current head entry
//   o_full, o_empty      occupancy flags
//   o_count              number of entries, 0..DEPTH
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  req_t                     i_push_req,
  input  logic                     i_pop,
  output req_t                     o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers are exactly AW bits wide, so the natural overflow wraps modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_push_req;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: queues upstream memory requests and issues them one at a
// time to mem_system, reporting each completion on the rsp_* port.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   in_valid/in_wr/in_addr/in_data    upstream request; in_ready = may accept
//   mem_Addr/mem_DataIn/mem_Rd/mem_Wr registered request to mem_system
//   mem_DataOut/mem_Done/mem_Stall/mem_CacheHit  mem_system reply
//   rsp_valid/rsp_wr/rsp_addr/rsp_data/rsp_hit   one-cycle completion report
//   n_req/n_hit/perf_err              performance counters (MEM_REQ_PERF_EN)
// Optional feature macro: MEM_REQ_PERF_EN
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_wr,
  input  logic [15:0] in_addr,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  output logic        mem_Rd,
  output logic        mem_Wr,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  input  logic        mem_Stall,
  input  logic        mem_CacheHit,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [15:0] rsp_addr,
  output logic [15:0] rsp_data,
  output logic        rsp_hit
`ifdef MEM_REQ_PERF_EN
  ,
  output logic [15:0] n_req,
  output logic [15:0] n_hit,
  output logic        perf_err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rst_done;
  req_t          w_push_req;
  req_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_issue;
  logic          w_complete;

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_done <= 1'b0;
    else      r_rst_done <= 1'b1;
  end

  assign in_ready   = r_rst_done && !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_push_req = '{wr: in_wr, addr: in_addr, data: in_data};

  mem_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_push     (w_push),
    .i_push_req (w_push_req),
    .i_pop      (w_issue),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // Occupancy flags must always agree with the entry count.
  always_ff @(posedge clk) begin
    if (rst) assert (w_full == (w_count == FULL_CNT) && w_empty == (w_count == '0));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty && !mem_Stall) w_state_nxt = ST_BUSY;
      ST_BUSY: if (mem_Done)               w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs (strobes consumed by the registered datapath below)
  always_comb begin
    w_issue    = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      ST_IDLE: w_issue    = !w_empty && !mem_Stall;
      ST_BUSY: w_complete = mem_Done;
      default: ;
    endcase
  end

  // Request and response registers. The request fields load only on issue,
  // so they stay put for the whole BUSY period whatever mem_Stall does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_Addr   <= '0;
      mem_DataIn <= '0;
      mem_Rd     <= 1'b0;
      mem_Wr     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_wr     <= 1'b0;
      rsp_addr   <= '0;
      rsp_data   <= '0;
      rsp_hit    <= 1'b0;
    end else begin
      rsp_valid <= w_complete;
      if (w_issue) begin
        mem_Addr   <= w_head.addr;
        mem_DataIn <= w_head.data;
        mem_Rd     <= !w_head.wr;
        mem_Wr     <= w_head.wr;
      end
      if (w_complete) begin
        mem_Rd   <= 1'b0;
        mem_Wr   <= 1'b0;
        rsp_wr   <= mem_Wr;
        rsp_addr <= mem_Addr;
        rsp_data <= mem_Wr ? mem_DataIn : mem_DataOut;
        rsp_hit  <= mem_CacheHit;
      end
    end
  end

`ifdef MEM_REQ_PERF_EN
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] w_lat_done;
  logic             w_lat_bad;

  // r_lat counts BUSY edges already passed; the completing edge is one more,
  // so a Done seen on the first edge after issue is latency 1.
  assign w_lat_done = (r_lat == '1) ? r_lat : r_lat + 1'b1;
  assign w_lat_bad  = mem_CacheHit ? (w_lat_done > HIT_MAX_LAT)
                                   : ((w_lat_done > MISS_MAX_LAT) || (w_lat_done <= HIT_MAX_LAT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat    <= '0;
      n_req    <= '0;
      n_hit    <= '0;
      perf_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_lat <= '0;
        if (n_req != '1) n_req <= n_req + 16'd1;
      end else if (r_state == ST_BUSY && r_lat != '1) begin
        r_lat <= r_lat + 1'b1;
      end
      if (w_complete && mem_CacheHit && n_hit != '1) n_hit <= n_hit + 16'd1;
      if ((w_complete && w_lat_bad) || (r_state == ST_IDLE && mem_Done)) perf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/mem_req_queue.md
MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, ≥2).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid in 1, in_wr in 1 (1=write, 0=read), in_addr in 16, in_data in 16: upstream request.
REQ-005 SHALL have port in_ready  out  1  queue can accept a request this cycle.
REQ-006 SHALL have ports mem_Addr out 16, mem_DataIn out 16, mem_Rd out 1, mem_Wr out 1: request to mem_system.
REQ-007 SHALL have ports mem_DataOut in 16, mem_Done in 1, mem_Stall in 1, mem_CacheHit in 1: mem_system reply.
REQ-008 SHALL have ports rsp_valid out 1, rsp_wr out 1, rsp_addr out 16, rsp_data out 16, rsp_hit out 1: completed-request report.
REQ-009 SHALL, with MEM_REQ_PERF_EN only, have ports n_req out 16, n_hit out 16, perf_err out 1.

Function
REQ-010 SHALL accept a request on a rising edge when in_valid && in_ready; in_ready = (count != DEPTH), independent of pop.
REQ-011 SHALL store requests in FIFO order; read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-012 SHALL, on push and pop in the same cycle, leave count unchanged; no bypass: an entry pushed into an empty queue issues no earlier than the next cycle.
REQ-013 SHALL implement issue FSM states IDLE and BUSY.
REQ-014 SHALL, in IDLE with count>0 and mem_Stall=0, pop the head, register it onto mem_Addr/mem_DataIn/mem_Rd/mem_Wr, and go to BUSY.
REQ-015 SHALL hold mem_Addr, mem_DataIn, mem_Rd, mem_Wr stable throughout BUSY, regardless of mem_Stall.
REQ-016 SHALL, in BUSY with mem_Done=1, go to IDLE and clear mem_Rd/mem_Wr on that edge; IDLE lasts at least one cycle between requests.
REQ-017 SHALL, on the edge ending BUSY, register rsp_valid=1 for exactly one cycle with rsp_wr, rsp_addr, rsp_hit=mem_CacheHit, and rsp_data=mem_DataOut for reads or the written data for writes.
REQ-018 SHALL ignore mem_Done while in IDLE; no response is produced.
REQ-019 SHALL keep exactly one request outstanding at mem_system.

Reset
REQ-020 SHALL, on rst low, immediately clear the queue, pointers, and count; set the FSM to IDLE; and drive mem_Rd=mem_Wr=0, mem_Addr=mem_DataIn=0, rsp_valid=0, rsp_*=0, and in_ready=0 while rst is low.
REQ-021 SHALL, if reset asserts mid-request, discard that request and all queued entries with no response.
REQ-022 SHALL, from the first edge after rst is released, drive in_ready=1.

Configuration
REQ-023 SHALL, with MEM_REQ_PERF_EN defined, count issued requests in n_req and hit completions in n_hit; both counters saturate at 0xFFFF and reset to 0.
REQ-024 SHALL, with MEM_REQ_PERF_EN defined, count BUSY cycles as latency (issue edge = 0).
REQ-025 SHALL, with MEM_REQ_PERF_EN defined, set sticky perf_err when a hit completes with latency >2, a miss completes with latency >20 or ≤2, or mem_Done is seen in IDLE; perf_err clears only on reset.
REQ-026 SHALL, without MEM_REQ_PERF_EN, omit the n_req, n_hit, and perf_err ports and logic, with datapath behaviour identical.

Structure
REQ-027 SHALL define the shared package mem_req_pkg with the request struct {wr, addr[15:0], data[15:0]}, the FSM state enum, and constants HIT_MAX_LAT=2 and MISS_MAX_LAT=20.
REQ-028 SHALL implement the storage as sub-module mem_req_fifo (DEPTH-parameterised, push/pop/full/empty/count); the FSM and perf logic stay in the top.

Verification
REQ-029 SHALL verify: push read 0x0010 into an empty queue, memory hits with Done 1 cycle after issue, DataOut 0x1234 -> mem_Rd high for 1 cycle, rsp_valid with rsp_data=0x1234 and rsp_hit=1, perf_err=0.
REQ-030 SHALL verify: push 5 requests with DEPTH=4 while mem_Stall=1 -> in_ready=0 after 4, fifth held; after release, requests issue in order and 5 responses are produced.
REQ-031 SHALL verify: write 0x0020/0xBEEF then read 0x0020 -> write response rsp_data=0xBEEF, read issued only after write Done, one IDLE cycle between.
REQ-032 SHALL verify: a miss with Done 25 cycles after issue -> perf_err=1 and sticky; a miss at 10 cycles -> no error.
REQ-033 SHALL verify: rst low while BUSY with 3 entries queued -> mem_Rd/mem_Wr=0 asynchronously, no rsp_valid, count=0 after release, and n_req=n_hit=0.
REQ-034 SHALL verify: mem_Done pulse while IDLE -> no rsp_valid, and perf_err=1 with MEM_REQ_PERF_EN defined.
